tdm_demux: RTL
==============

# tdm_demux

- Time-division demultiplexer: takes one shared data stream carrying CHANNELS interleaved slots and writes each slot to its own per-channel output register.
- A frame-sync strobe marks slot 0.
- Sits downstream of the team's channel multiplexers and rebuilds parallel channel data from the shared line.
- Registered outputs; one-cycle strobes mark each channel update and each completed frame.

## Interface
Parameters:
- WIDTH, 8, data width of one slot
- CHANNELS, 4, slots per frame; legal range 2..16

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- d_in  input  WIDTH  slot data on the shared line
- d_valid  input  1  d_in carries a slot this cycle
- frame_sync  input  1  qualified by d_valid; this beat is slot 0
- ch_out  output  CHANNELS*WIDTH  channel i is bits [i*WIDTH +: WIDTH]; holds its last value
- ch_valid  output  CHANNELS  one-cycle pulse, bit i = channel i updated this cycle
- frame_done  output  1  one-cycle pulse when slot CHANNELS-1 is written
- sync_err  output  1  one-cycle pulse on a framing error (see Configuration)
- slot  output  clog2(CHANNELS)  index of the next expected slot

## Operation
- States:
  - HUNT: waiting for frame alignment.
  - RUN: aligned to frames.
- Reset (asynchronous): state HUNT; slot=0; ch_out, ch_valid, frame_done and sync_err all 0.
- Beats: only cycles with d_valid=1 are beats. Non-beat cycles change nothing, and all pulse outputs are 0 on the following edge.
- HUNT:
  - A beat with frame_sync=0 is discarded.
  - A beat with frame_sync=1 is written to channel 0; slot becomes 1; state moves to RUN.
- RUN:
  - Each beat is written to channel `slot`, and slot increments.
  - After slot CHANNELS-1 is written, slot wraps to 0, frame_done pulses, and state stays RUN.
- Write effects: a write to channel i sets ch_out[i] and ch_valid[i] on the same edge. Other channels hold their values.
- Counter width: slot uses clog2(CHANNELS) bits. The wrap is explicit (compare against CHANNELS-1), so non-power-of-two CHANNELS never reaches an illegal index.
- Reset mid-frame: returns to HUNT immediately. Partially filled channels are cleared to 0. No frame_done is emitted.

## Timing
- Latency: 1 cycle from a beat to its ch_out / ch_valid update.
- frame_done is asserted in the same cycle as ch_valid[CHANNELS-1].
- Throughput: one slot per cycle; back-to-back frames need no idle cycles.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: TDM_DEMUX_SYNC_CHECK_EN.
- Defined: RUN checks framing on every beat.
  - Beat at slot 0 without frame_sync: sync_err pulses, the beat is discarded, slot goes to 0, state goes to HUNT.
  - Beat at slot≠0 with frame_sync: sync_err pulses, and the beat is treated as a new slot 0 (written to channel 0, slot=1, state stays RUN). frame_done is not pulsed for the aborted frame.
- Undefined: frame_sync is ignored in RUN, slots wrap freely, and sync_err is tied to 0.

## Test plan
WIDTH=8, CHANNELS=4.
1. Reset, then beats 0x11(sync), 0x22, 0x33, 0x44 on consecutive cycles -> ch_valid = 0001, 0010, 0100, 1000 on consecutive cycles; frame_done coincides with 1000; ch_out = 0x44332211.
2. In HUNT, beats 0xAA, 0xBB without sync -> no ch_valid, slot stays 0; then 0x01 with sync -> ch_out[7:0]=0x01, slot=1.
3. Gaps: d_valid pulses every other cycle across two frames -> each update lands 1 cycle after its beat, nothing changes in gap cycles, frame_done fires twice.
4. Reset asserted after two slots, mid-frame -> outputs go to 0 at once; after release, no output until a sync beat arrives.
5. With the macro defined, a sync beat arrives at slot 2 -> sync_err pulse, ch_valid=0001, slot=1, no frame_done. A no-sync beat at slot 0 -> sync_err pulse, state HUNT.
6. Without the macro, same stimulus as test 5 -> sync_err stays 0; the sync beat is written to channel 2 and normal wrap continues.

Source files
------------

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: spreads the interleaved slots of one shared line onto per-channel registers.
// Optional framing check on every aligned beat when TDM_DEMUX_SYNC_CHECK_EN is defined.
module tdm_demux_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_vld
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q   <= '0;
      o_vld <= 1'b0;
    end else begin
      o_vld <= i_wr;
      if (i_wr) o_q <= i_d;
    end
  end
endmodule

module tdm_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SW      = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          d_in,
  input  logic                      d_valid,
  input  logic                      frame_sync,
  output logic [CHANNELS*WIDTH-1:0] ch_out,
  output logic [CHANNELS-1:0]       ch_valid,
  output logic                      frame_done,
  output logic                      sync_err,
  output logic [SW-1:0]             slot
);
  typedef enum logic {HUNT, RUN} state_t;

  localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);

  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_slot, w_slot_nxt;
  logic [SW-1:0] w_idx;
  logic          w_wr, w_done, w_err;
  logic          r_frame_done, r_sync_err;
  logic [CHANNELS-1:0]            w_lane_wr;
  logic [CHANNELS-1:0][WIDTH-1:0] w_lane_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= HUNT;
      r_slot       <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_slot       <= w_slot_nxt;
      r_frame_done <= w_done;
      r_sync_err   <= w_err;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_idx       = r_slot;
    w_wr        = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    if (d_valid) begin
      case (r_state)
        HUNT: begin
          if (frame_sync) begin
            w_wr        = 1'b1;
            w_idx       = '0;
            w_slot_nxt  = SW'(1);
            w_state_nxt = RUN;
          end
        end
        RUN: begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
          if (r_slot == '0 && !frame_sync) begin
            w_err       = 1'b1;
            w_slot_nxt  = '0;
            w_state_nxt = HUNT;
          end else if (r_slot != '0 && frame_sync) begin
            // Early sync restarts the frame; the aborted one never reports done.
            w_err      = 1'b1;
            w_wr       = 1'b1;
            w_idx      = '0;
            w_slot_nxt = SW'(1);
          end else
`endif
          begin
            w_wr = 1'b1;
            if (r_slot == LAST) begin
              w_slot_nxt = '0;
              w_done     = 1'b1;
            end else begin
              w_slot_nxt = r_slot + SW'(1);
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    w_lane_wr = '0;
    if (w_wr) w_lane_wr[w_idx] = 1'b1;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    tdm_demux_lane #(.WIDTH(WIDTH)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .i_wr (w_lane_wr[g]),
      .i_d  (d_in),
      .o_q  (w_lane_q[g]),
      .o_vld(ch_valid[g])
    );
  end

  assign ch_out     = w_lane_q;
  assign frame_done = r_frame_done;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
  assign sync_err   = r_sync_err;
`else
  assign sync_err   = 1'b0;
`endif
  assign slot       = r_slot;
endmodule
